ex_muldiv_unit: RTL

- Multi-cycle multiply/divide unit in the EX stage. Consumes operand_1/operand_2 as produced by ID operand generation and registered by the ID/EX latch.
- Executes MULT, MULTU, DIV and DIVU iteratively into architectural HI/LO registers, and handles MTHI/MTLO.
- Holds the pipeline via stall_request while an operation is in flight.

---
 rtl/ex_muldiv_unit_pkg.sv | 29 ++
 rtl/ex_muldiv_core.sv | 77 +++++++
 rtl/ex_muldiv_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit and the ID decoder that feeds it.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_muldiv_unit_pkg;

    localparam int MULDIV_OP_BUS = 3;

    typedef enum logic [MULDIV_OP_BUS-1:0] {
        MULDIV_NONE  = 3'd0,
        MULDIV_MULT  = 3'd1,
        MULDIV_MULTU = 3'd2,
        MULDIV_DIV   = 3'd3,
        MULDIV_DIVU  = 3'd4,
        MULDIV_MTHI  = 3'd5,
        MULDIV_MTLO  = 3'd6
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    // True for the four iterative ops (MULT, MULTU, DIV, DIVU).
    function automatic logic is_arith_op(input logic [MULDIV_OP_BUS-1:0] op);
        return (op >= MULDIV_MULT) && (op <= MULDIV_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Iterative unsigned radix-2 engine: shift-add multiply or restoring divide on magnitudes.
// Latency: DATA_WIDTH step cycles after start; done is high during the last step cycle.
// Backpressure: none; abort drops the operation, caller owns all sequencing.
module ex_muldiv_core #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    is_div,
    input  logic [DATA_WIDTH-1:0]   mag_a,
    input  logic [DATA_WIDTH-1:0]   mag_b,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    done
);

    // acc holds {hi, lo}: multiply shifts the product in from the top while the
    // multiplier drains out of the bottom; divide keeps {remainder, quotient}.
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [2*DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0]   opnd_q;
    logic                    is_div_q;
    logic                    busy_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH:0]     div_sh;
    logic [DATA_WIDTH:0]     div_diff;

    assign result = acc_q;
    assign done   = busy_q && (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));

    // One radix-2 step of whichever operation is loaded.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, opnd_q};
        div_sh   = acc_q[2*DATA_WIDTH-1:DATA_WIDTH-1];
        div_diff = div_sh - {1'b0, opnd_q};
        acc_next = acc_q;
        if (is_div_q) begin
            if (div_sh >= {1'b0, opnd_q})
                acc_next = {div_diff[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b1};
            else
                acc_next = {div_sh[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            if (acc_q[0])
                acc_next = {mul_sum, acc_q[DATA_WIDTH-1:1]};
            else
                acc_next = {1'b0, acc_q[2*DATA_WIDTH-1:1]};
        end
    end

    // Load on start, then step once per cycle until the last step retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (abort) begin
            busy_q <= 1'b0;
        end else if (start) begin
            acc_q    <= is_div ? {{DATA_WIDTH{1'b0}}, mag_a} : {{DATA_WIDTH{1'b0}}, mag_b};
            opnd_q   <= is_div ? mag_b : mag_a;
            is_div_q <= is_div;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
        end else if (busy_q) begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (done)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: sequencing FSM, sign handling, flush, HI/LO registers.
// Latency: issue + DATA_WIDTH run cycles + 1 done cycle; divide-by-zero is issue + done.
// Backpressure: stall_request holds the pipeline while an op is in flight; flush drops it.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [MULDIV_OP_BUS-1:0] muldiv_op,
    input  logic [DATA_WIDTH-1:0]    operand_1,
    input  logic [DATA_WIDTH-1:0]    operand_2,
    output logic                     stall_request,
    output logic                     result_valid,
    output logic [DATA_WIDTH-1:0]    hi,
    output logic [DATA_WIDTH-1:0]    lo
);

    muldiv_state_e           state_q, state_d;
    logic                    op_arith, op_signed, op_div, div_zero, issue;
    logic [DATA_WIDTH-1:0]   mag_a, mag_b;
    logic                    core_done;
    logic [2*DATA_WIDTH-1:0] core_result;
    logic                    div_q, dz_q, neg_main_q, neg_rem_q;
    logic [DATA_WIDTH-1:0]   raw_a_q;
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;

    assign op_arith  = is_arith_op(muldiv_op);
    assign op_signed = (muldiv_op == MULDIV_MULT) || (muldiv_op == MULDIV_DIV);
    assign op_div    = (muldiv_op == MULDIV_DIV) || (muldiv_op == MULDIV_DIVU);
    assign div_zero  = op_div && (operand_2 == '0);
    assign issue     = (state_q == ST_IDLE) && op_arith && !flush;
    assign mag_a     = (op_signed && operand_1[DATA_WIDTH-1]) ? -operand_1 : operand_1;
    assign mag_b     = (op_signed && operand_2[DATA_WIDTH-1]) ? -operand_2 : operand_2;

    ex_muldiv_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (issue && !div_zero),
        .abort  (flush),
        .is_div (op_div),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .result (core_result),
        .done   (core_done)
    );

    // Next state and pipeline handshake; flush always wins over the hold.
    always_comb begin
        state_d       = state_q;
        stall_request = 1'b0;
        result_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_request = op_arith && !flush;
                if (issue)
                    state_d = div_zero ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                stall_request = !flush;
                if (flush)
                    state_d = ST_IDLE;
                else if (core_done)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                result_valid = !flush;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Capture sign-fix flags and the raw dividend at issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= 1'b0;
            dz_q       <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            raw_a_q    <= '0;
        end else if (issue) begin
            div_q      <= op_div;
            dz_q       <= div_zero;
            neg_main_q <= op_signed && (operand_1[DATA_WIDTH-1] ^ operand_2[DATA_WIDTH-1]);
            neg_rem_q  <= op_signed && operand_1[DATA_WIDTH-1];
            raw_a_q    <= operand_1;
        end
    end

    // Signed fix-up of the magnitude result; divide-by-zero bypasses the engine.
    always_comb begin
        prod_fix = neg_main_q ? -core_result : core_result;
        quo_fix  = neg_main_q ? -core_result[DATA_WIDTH-1:0] : core_result[DATA_WIDTH-1:0];
        rem_fix  = neg_rem_q ? -core_result[2*DATA_WIDTH-1:DATA_WIDTH]
                             : core_result[2*DATA_WIDTH-1:DATA_WIDTH];
        if (dz_q) begin
            hi_res = raw_a_q;
            lo_res = '1;
        end else if (div_q) begin
            hi_res = rem_fix;
            lo_res = quo_fix;
        end else begin
            hi_res = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            lo_res = prod_fix[DATA_WIDTH-1:0];
        end
    end

    // Architectural HI/LO: results from DONE, direct moves only from an unflushed IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (result_valid) begin
            hi <= hi_res;
            lo <= lo_res;
        end else if ((state_q == ST_IDLE) && !flush) begin
            if (muldiv_op == MULDIV_MTHI)
                hi <= operand_1;
            if (muldiv_op == MULDIV_MTLO)
                lo <= operand_1;
        end
    end

endmodule
